// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), then ALU (A3-A5) or mul/div (M3-M6)
// execute phases; Moore strobes decoded from the state register.
module control_sequencer #(
  parameter logic [4:0] NOP_OP  = 5'b11010,
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  opcode,
  output logic        Run
);

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, A3, A4, A5, M3, M4, M5, M6, HALT
  } state_t;

  state_t     state, next_state;
  logic [4:0] op;
  state_t     end_state;
  logic       ir_unused;

  assign op        = IR[31:27];
  assign ir_unused = ^IR[26:0];
  assign end_state = stop ? HALT : T0;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= RESET;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    opcode   = '0;
    Run      = (state != RESET) && (state != HALT);

    case (state)
      RESET: next_state = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
        next_state = T1;
      end
      T1: begin
        Read = 1'b1; MDRin = 1'b1;
        next_state = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        // Unlisted opcodes finish like a nop
        if (op >= 5'b00011 && op <= 5'b01110)      next_state = A3;
        else if (op == 5'b01111 || op == 5'b10000) next_state = M3;
        else if (op == HALT_OP)                    next_state = HALT;
        else if (op == NOP_OP)                     next_state = end_state;
        else                                       next_state = end_state;
      end
      A3: begin
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        next_state = A4;
      end
      A4: begin
        Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = op;
        next_state = A5;
      end
      A5: begin
        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        next_state = end_state;
      end
      M3: begin
        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        next_state = M4;
      end
      M4: begin
        Grb = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; opcode = op;
        next_state = M5;
      end
      M5: begin
        Zlowout = 1'b1; LOin = 1'b1;
        next_state = M6;
      end
      M6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        next_state = end_state;
      end
      HALT:    next_state = HALT;
      default: next_state = RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer: table of per-cycle
// {IR, stop, expected outputs} plus hand sequences for clear/halt corners.
module tb_control_sequencer;

  logic        clock, clear, stop;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Gra, Grb, Grc, Rin, Rout, Yin, ZLowIn, ZHighIn;
  logic Zlowout, Zhighout, HIin, LOin, Run;
  logic [4:0] opcode;

  control_sequencer #(.NOP_OP(5'b11010), .HALT_OP(5'b11011)) dut (
    .clock(clock), .clear(clear), .IR(IR), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .opcode(opcode), .Run(Run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [19:0] PCOUT  = 20'd1 << 19, PCIN    = 20'd1 << 18;
  localparam logic [19:0] INCPC  = 20'd1 << 17, MARIN   = 20'd1 << 16;
  localparam logic [19:0] READ   = 20'd1 << 15, MDRIN   = 20'd1 << 14;
  localparam logic [19:0] MDROUT = 20'd1 << 13, IRIN    = 20'd1 << 12;
  localparam logic [19:0] GRA    = 20'd1 << 11, GRB     = 20'd1 << 10;
  localparam logic [19:0] GRC    = 20'd1 << 9,  RIN     = 20'd1 << 8;
  localparam logic [19:0] ROUT   = 20'd1 << 7,  YIN     = 20'd1 << 6;
  localparam logic [19:0] ZLOWIN = 20'd1 << 5,  ZHIGHIN = 20'd1 << 4;
  localparam logic [19:0] ZLOWOUT = 20'd1 << 3, ZHIGHOUT = 20'd1 << 2;
  localparam logic [19:0] HIIN   = 20'd1 << 1,  LOIN    = 20'd1 << 0;

  typedef struct packed {
    logic [19:0] strb;
    logic [4:0]  opc;
    logic        run;
  } exp_t;

  localparam exp_t X_RESET = {20'd0, 5'd0, 1'b0};
  localparam exp_t X_HALT  = {20'd0, 5'd0, 1'b0};
  localparam exp_t X_T0    = {PCOUT | MARIN | INCPC | PCIN, 5'd0, 1'b1};
  localparam exp_t X_T1    = {READ | MDRIN, 5'd0, 1'b1};
  localparam exp_t X_T2    = {MDROUT | IRIN, 5'd0, 1'b1};
  localparam exp_t X_A3    = {GRB | ROUT | YIN, 5'd0, 1'b1};
  localparam exp_t X_A4    = {GRC | ROUT | ZLOWIN, 5'b00101, 1'b1};
  localparam exp_t X_A5    = {ZLOWOUT | GRA | RIN, 5'd0, 1'b1};
  localparam exp_t X_M3    = {GRA | ROUT | YIN, 5'd0, 1'b1};
  localparam exp_t X_M4    = {GRB | ROUT | ZLOWIN | ZHIGHIN, 5'b01111, 1'b1};
  localparam exp_t X_M5    = {ZLOWOUT | LOIN, 5'd0, 1'b1};
  localparam exp_t X_M6    = {ZHIGHOUT | HIIN, 5'd0, 1'b1};

  localparam logic [31:0] IR_ADD  = 32'h2A1B8000;  // op 00101, R4 <- R3 op R7
  localparam logic [31:0] IR_MUL  = 32'h7A000000;  // op 01111
  localparam logic [31:0] IR_NOP  = 32'hD0000000;  // op 11010
  localparam logic [31:0] IR_HALT = 32'hD8000000;  // op 11011

  typedef struct {
    logic [31:0] ir;
    logic        stp;
    exp_t        exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic exp_t actual();
    return {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
            Gra, Grb, Grc, Rin, Rout, Yin, ZLowIn, ZHighIn,
            Zlowout, Zhighout, HIin, LOin, opcode, Run};
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got strobes=%05h opcode=%05b run=%b, expected strobes=%05h opcode=%05b run=%b",
               name, act.strb, act.opc, act.run, exp.strb, exp.opc, exp.run);
    end
  endtask

  task automatic add(input logic [31:0] ir, input logic stp, input exp_t exp, input string name);
    vec_t v;
    v.ir = ir; v.stp = stp; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, check the state entered.
  task automatic step(input logic [31:0] ir, input logic stp, input exp_t exp, input string name);
    IR = ir;
    stop = stp;
    @(posedge clock);
    #1;
    check(name, exp);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    stop = 1'b0;
    #1;
    check("clear_async", X_RESET);
    @(posedge clock);
    #1;
    check("clear_held", X_RESET);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    stop  = 1'b0;
    IR    = '0;

    add(IR_ADD, 0, X_T0, "add_T0");  add(IR_ADD, 0, X_T1, "add_T1");
    add(IR_ADD, 0, X_T2, "add_T2");  add(IR_ADD, 0, X_A3, "add_A3");
    add(IR_ADD, 0, X_A4, "add_A4");  add(IR_ADD, 0, X_A5, "add_A5");
    add(IR_ADD, 0, X_T0, "add_next_T0");
    add(IR_MUL, 0, X_T1, "mul_T1");  add(IR_MUL, 0, X_T2, "mul_T2");
    add(IR_MUL, 0, X_M3, "mul_M3");  add(IR_MUL, 0, X_M4, "mul_M4");
    add(IR_MUL, 0, X_M5, "mul_M5");  add(IR_MUL, 0, X_M6, "mul_M6");
    add(IR_MUL, 0, X_T0, "mul_next_T0");
    add(IR_NOP, 0, X_T1, "nop_T1");  add(IR_NOP, 0, X_T2, "nop_T2");
    add(IR_NOP, 0, X_T0, "nop_next_T0");
    // stop high only at the edge ending A4: ignored
    add(IR_ADD, 0, X_T1, "stpA4_T1"); add(IR_ADD, 0, X_T2, "stpA4_T2");
    add(IR_ADD, 0, X_A3, "stpA4_A3"); add(IR_ADD, 0, X_A4, "stpA4_A4");
    add(IR_ADD, 1, X_A5, "stpA4_A5"); add(IR_ADD, 0, X_T0, "stpA4_T0");
    // stop held through A5: halts at the instruction boundary
    add(IR_ADD, 0, X_T1, "stpA5_T1"); add(IR_ADD, 0, X_T2, "stpA5_T2");
    add(IR_ADD, 0, X_A3, "stpA5_A3"); add(IR_ADD, 0, X_A4, "stpA5_A4");
    add(IR_ADD, 1, X_A5, "stpA5_A5"); add(IR_ADD, 1, X_HALT, "stpA5_HALT");

    #2;
    check("reset_initial", X_RESET);
    @(posedge clock);
    #1;
    check("reset_held", X_RESET);
    clear = 1'b0;

    foreach (vecs[i]) step(vecs[i].ir, vecs[i].stp, vecs[i].exp, vecs[i].name);

    for (int unsigned i = 0; i < 22; i++)
      step($urandom, 1'($urandom_range(0, 1)), X_HALT, "halt_stays");

    // HALT opcode, then clear releases via RESET to T0
    clear_pulse();
    step(IR_HALT, 0, X_T0, "hop_T0");
    step(IR_HALT, 0, X_T1, "hop_T1");
    step(IR_HALT, 0, X_T2, "hop_T2");
    step(IR_HALT, 0, X_HALT, "hop_HALT");
    step(IR_ADD, 0, X_HALT, "hop_HALT2");
    clear_pulse();
    step(IR_NOP, 0, X_T0, "hop_release_T0");

    // nop with stop at the T2 boundary halts
    step(IR_NOP, 0, X_T1, "nopstp_T1");
    step(IR_NOP, 0, X_T2, "nopstp_T2");
    step(IR_NOP, 1, X_HALT, "nopstp_HALT");

    // clear mid-A4 must drop strobes before the next edge
    clear_pulse();
    step(IR_ADD, 0, X_T0, "clrA4_T0");
    step(IR_ADD, 0, X_T1, "clrA4_T1");
    step(IR_ADD, 0, X_T2, "clrA4_T2");
    step(IR_ADD, 0, X_A3, "clrA4_A3");
    step(IR_ADD, 0, X_A4, "clrA4_A4");
    #3;
    clear = 1'b1;
    #1;
    check("clrA4_async_drop", X_RESET);
    @(posedge clock);
    #1;
    check("clrA4_reset_held", X_RESET);
    clear = 1'b0;
    step(IR_ADD, 0, X_T0, "clrA4_release_T0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
